vga_cmd_pattern_gen: RTL

//  UART-commanded VGA pattern generator with integrated sync/porch timing, generalised from the 640x480
//  3-bit pattern top: parametrised colour depth and timing, a multi-byte command protocol with a

---
 rtl/vga_cmd_pattern_gen_pkg.sv | 28 ++
 rtl/vga_cmd_pattern_gen_if.sv | 28 ++
 rtl/vga_cmd_pattern_gen_timing_counter.sv | 57 +++++
 rtl/vga_cmd_pattern_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_cmd_pattern_gen_pkg.sv
// Shared constants and types for the UART-commanded VGA pattern generator.
package vga_cmd_pattern_gen_pkg;

    localparam logic [7:0] OP_PATTERN  = 8'h50;
    localparam logic [7:0] OP_COLOUR   = 8'h43;

    localparam logic [3:0] PAT_BLACK   = 4'd0;
    localparam logic [3:0] PAT_SOLID   = 4'd1;
    localparam logic [3:0] PAT_BARS    = 4'd2;
    localparam logic [3:0] PAT_CHECK   = 4'd3;
    localparam logic [3:0] PAT_BORDER  = 4'd4;
    localparam logic [3:0] PAT_RAMP    = 4'd5;
    localparam logic [3:0] MAX_PATTERN = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P_ARG,
        ST_C_R,
        ST_C_G,
        ST_C_B
    } parse_state_t;

    // A pattern argument is valid only with a clear upper nibble and a known index.
    function automatic logic pattern_arg_ok(input logic [7:0] b);
        return (b[7:4] == 4'd0) && (b[3:0] <= MAX_PATTERN);
    endfunction

endpackage

// File: rtl/vga_cmd_pattern_gen_if.sv
// Byte command stream in, VGA pins and status pulses out.
interface vga_cmd_pattern_gen_if #(
    parameter int VIDEO_WIDTH = 3
);
    logic                   i_RX_DV;
    logic [7:0]             i_RX_Byte;
    logic                   o_HSync;
    logic                   o_VSync;
    logic [VIDEO_WIDTH-1:0] o_Red_Video;
    logic [VIDEO_WIDTH-1:0] o_Grn_Video;
    logic [VIDEO_WIDTH-1:0] o_Blu_Video;
    logic [3:0]             o_Pattern;
    logic                   o_Cmd_Done;
    logic                   o_Cmd_Err;
    logic                   o_Frame_Start;

    modport master (
        output i_RX_DV, i_RX_Byte,
        input  o_HSync, o_VSync, o_Red_Video, o_Grn_Video, o_Blu_Video,
        input  o_Pattern, o_Cmd_Done, o_Cmd_Err, o_Frame_Start
    );

    modport slave (
        input  i_RX_DV, i_RX_Byte,
        output o_HSync, o_VSync, o_Red_Video, o_Grn_Video, o_Blu_Video,
        output o_Pattern, o_Cmd_Done, o_Cmd_Err, o_Frame_Start
    );
endinterface

// File: rtl/vga_cmd_pattern_gen_timing_counter.sv
// Column/row raster counters with combinational active, sync and end-of-line/frame decode.
module vga_timing_counter #(
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int H_FRONT     = 18,
    parameter int H_SYNC      = 92,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int COL_W       = 10,
    parameter int ROW_W       = 10
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic             o_active,
    output logic             o_hsync_n,
    output logic             o_vsync_n,
    output logic             o_line_end,
    output logic             o_frame_end
);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(TOTAL_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TOTAL_ROWS - 1);
    localparam logic [COL_W-1:0] COL_ACT  = COL_W'(ACTIVE_COLS);
    localparam logic [ROW_W-1:0] ROW_ACT  = ROW_W'(ACTIVE_ROWS);
    localparam logic [COL_W-1:0] HS_BEG   = COL_W'(ACTIVE_COLS + H_FRONT);
    localparam logic [COL_W-1:0] HS_END   = COL_W'(ACTIVE_COLS + H_FRONT + H_SYNC);
    localparam logic [ROW_W-1:0] VS_BEG   = ROW_W'(ACTIVE_ROWS + V_FRONT);
    localparam logic [ROW_W-1:0] VS_END   = ROW_W'(ACTIVE_ROWS + V_FRONT + V_SYNC);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    // Raster scan: column wraps into the next row, row wraps at end of frame.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_col <= '0;
            r_row <= '0;
        end else if (r_col == COL_LAST) begin
            r_col <= '0;
            r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
            r_col <= r_col + 1'b1;
        end
    end

    assign o_col       = r_col;
    assign o_row       = r_row;
    assign o_active    = (r_col < COL_ACT) && (r_row < ROW_ACT);
    assign o_hsync_n   = !((r_col >= HS_BEG) && (r_col < HS_END));
    assign o_vsync_n   = !((r_row >= VS_BEG) && (r_row < VS_END));
    assign o_line_end  = (r_col == COL_LAST);
    assign o_frame_end = (r_col == COL_LAST) && (r_row == ROW_LAST);

endmodule

// File: rtl/vga_cmd_pattern_gen.sv
// UART-commanded VGA pattern generator: command parser, frame-synchronous
// pattern/colour update and registered video/sync outputs.
module vga_cmd_pattern_gen
    import vga_cmd_pattern_gen_pkg::*;
#(
    parameter int VIDEO_WIDTH = 3,
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int H_FRONT     = 18,
    parameter int H_SYNC      = 92,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int CHECK_LOG2  = 5
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    vga_cmd_pattern_gen_if.slave  vga_bus
);
    // Column is at least 10 bits so the grey ramp can always take col[9 -: VW].
    localparam int COL_W = ($clog2(TOTAL_COLS + 1) > 10) ? $clog2(TOTAL_COLS + 1) : 10;
    localparam int ROW_W = $clog2(TOTAL_ROWS + 1);
    localparam int VW    = VIDEO_WIDTH;

    localparam logic [COL_W-1:0] BAR_LAST = COL_W'(ACTIVE_COLS / 8 - 1);
    localparam logic [COL_W-1:0] COL_EDGE = COL_W'(ACTIVE_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_EDGE = ROW_W'(ACTIVE_ROWS - 1);
    localparam logic [VW-1:0]    CH_MAX   = '1;

    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic             w_active, w_hsync_n, w_vsync_n, w_line_end, w_frame_end;
    logic [VW-1:0]    w_red, w_grn, w_blu;

    parse_state_t     r_state;
    logic [VW-1:0]    r_sh_r, r_sh_g;
    logic [3:0]       r_pend_pat, r_live_pat;
    logic [VW-1:0]    r_pend_r, r_pend_g, r_pend_b;
    logic [VW-1:0]    r_live_r, r_live_g, r_live_b;
    logic [COL_W-1:0] r_bar_cnt;
    logic [2:0]       r_bar_idx;
    logic             r_done, r_err;
    logic             r_hsync, r_vsync, r_frame_start;
    logic [VW-1:0]    r_red, r_grn, r_blu;

    vga_timing_counter #(
        .TOTAL_COLS (TOTAL_COLS),  .TOTAL_ROWS (TOTAL_ROWS),
        .ACTIVE_COLS(ACTIVE_COLS), .ACTIVE_ROWS(ACTIVE_ROWS),
        .H_FRONT    (H_FRONT),     .H_SYNC     (H_SYNC),
        .V_FRONT    (V_FRONT),     .V_SYNC     (V_SYNC),
        .COL_W      (COL_W),       .ROW_W      (ROW_W)
    ) u_timing (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .o_col      (w_col),
        .o_row      (w_row),
        .o_active   (w_active),
        .o_hsync_n  (w_hsync_n),
        .o_vsync_n  (w_vsync_n),
        .o_line_end (w_line_end),
        .o_frame_end(w_frame_end)
    );

    // Command parser: argument bytes are consumed by their state, never decoded as opcodes.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_state    <= ST_IDLE;
            r_sh_r     <= '0;
            r_sh_g     <= '0;
            r_pend_pat <= PAT_BLACK;
            r_pend_r   <= '0;
            r_pend_g   <= '0;
            r_pend_b   <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (vga_bus.i_RX_DV) begin
                case (r_state)
                    ST_IDLE: begin
                        if (vga_bus.i_RX_Byte == OP_PATTERN)     r_state <= ST_P_ARG;
                        else if (vga_bus.i_RX_Byte == OP_COLOUR) r_state <= ST_C_R;
                        else                                     r_err   <= 1'b1;
                    end
                    ST_P_ARG: begin
                        if (pattern_arg_ok(vga_bus.i_RX_Byte)) begin
                            r_pend_pat <= vga_bus.i_RX_Byte[3:0];
                            r_done     <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                    ST_C_R: begin
                        r_sh_r  <= vga_bus.i_RX_Byte[7 -: VW];
                        r_state <= ST_C_G;
                    end
                    ST_C_G: begin
                        r_sh_g  <= vga_bus.i_RX_Byte[7 -: VW];
                        r_state <= ST_C_B;
                    end
                    ST_C_B: begin
                        r_pend_r <= r_sh_r;
                        r_pend_g <= r_sh_g;
                        r_pend_b <= vga_bus.i_RX_Byte[7 -: VW];
                        r_done   <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Pending settings become live only on the last pixel of a frame, so no frame tears.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_live_pat <= PAT_BLACK;
            r_live_r   <= '0;
            r_live_g   <= '0;
            r_live_b   <= '0;
        end else if (w_frame_end) begin
            r_live_pat <= r_pend_pat;
            r_live_r   <= r_pend_r;
            r_live_g   <= r_pend_g;
            r_live_b   <= r_pend_b;
        end
    end

    // Bar index tracks the column in steps of ACTIVE_COLS/8, saturating at 7 past the active area.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L || w_line_end) begin
            r_bar_cnt <= '0;
            r_bar_idx <= 3'd0;
        end else if (r_bar_cnt == BAR_LAST) begin
            r_bar_cnt <= '0;
            r_bar_idx <= (r_bar_idx == 3'd7) ? 3'd7 : r_bar_idx + 3'd1;
        end else begin
            r_bar_cnt <= r_bar_cnt + 1'b1;
        end
    end

    // Pattern generator for the current raster position.
    always_comb begin
        w_red = '0;
        w_grn = '0;
        w_blu = '0;
        case (r_live_pat)
            PAT_BLACK: ;
            PAT_SOLID: begin
                w_red = r_live_r;
                w_grn = r_live_g;
                w_blu = r_live_b;
            end
            PAT_BARS: begin
                w_red = {VW{r_bar_idx[0]}};
                w_grn = {VW{r_bar_idx[1]}};
                w_blu = {VW{r_bar_idx[2]}};
            end
            PAT_CHECK: begin
                w_red = {VW{w_col[CHECK_LOG2] ^ w_row[CHECK_LOG2]}};
                w_grn = w_red;
                w_blu = w_red;
            end
            PAT_BORDER: begin
                if (w_row == '0 || w_row == ROW_EDGE || w_col == '0 || w_col == COL_EDGE)
                    w_red = CH_MAX;
                w_grn = w_red;
                w_blu = w_red;
            end
            PAT_RAMP: begin
                w_red = w_col[9 -: VW];
                w_grn = w_red;
                w_blu = w_red;
            end
            default: ;
        endcase
    end

    // Output stage: everything one clock behind the counters, video blanked outside active area.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
            r_red         <= '0;
            r_grn         <= '0;
            r_blu         <= '0;
        end else begin
            r_hsync       <= w_hsync_n;
            r_vsync       <= w_vsync_n;
            r_frame_start <= (w_col == '0) && (w_row == '0);
            r_red         <= w_active ? w_red : '0;
            r_grn         <= w_active ? w_grn : '0;
            r_blu         <= w_active ? w_blu : '0;
        end
    end

    assign vga_bus.o_HSync       = r_hsync;
    assign vga_bus.o_VSync       = r_vsync;
    assign vga_bus.o_Red_Video   = r_red;
    assign vga_bus.o_Grn_Video   = r_grn;
    assign vga_bus.o_Blu_Video   = r_blu;
    assign vga_bus.o_Pattern     = r_live_pat;
    assign vga_bus.o_Cmd_Done    = r_done;
    assign vga_bus.o_Cmd_Err     = r_err;
    assign vga_bus.o_Frame_Start = r_frame_start;

endmodule
